// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one single-cycle SRAM port between NumReq
// requesters. A tag pipeline as deep as the SRAM read latency returns each
// read response to the requester that issued it.
module sram_port_arbiter #(
  parameter int NumReq    = 4,
  parameter int AddrWidth = 10,
  parameter int DataWidth = 32,
  parameter int BeWidth   = 4,
  parameter int Latency   = 1,
  parameter int IdWidth   = $clog2(NumReq)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_i,
  input  logic [NumReq-1:0]                  we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
  input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
  output logic [NumReq-1:0]                  gnt_o,
  output logic [NumReq-1:0]                  rvalid_o,
  output logic [DataWidth-1:0]               rdata_o,
  output logic                               sram_req_o,
  output logic                               sram_we_o,
  output logic [AddrWidth-1:0]               sram_addr_o,
  output logic [DataWidth-1:0]               sram_wdata_o,
  output logic [BeWidth-1:0]                 sram_be_o,
  input  logic [DataWidth-1:0]               sram_rdata_i
);

  logic [IdWidth-1:0]              ptr_q;
  logic [IdWidth-1:0]              gidx;
  logic                            found;
  logic                            grant;
  logic [IdWidth:0]                sum;
  logic [Latency-1:0]              vld_pipe;
  logic [Latency-1:0][IdWidth-1:0] id_pipe;

  // Search upward from the priority pointer, wrapping, for the first request.
  always_comb begin
    gidx  = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < NumReq; i++) begin
      sum = {1'b0, ptr_q} + (IdWidth+1)'(i);
      if (sum >= (IdWidth+1)'(NumReq)) sum = sum - (IdWidth+1)'(NumReq);
      if (!found && req_i[sum[IdWidth-1:0]]) begin
        found = 1'b1;
        gidx  = sum[IdWidth-1:0];
      end
    end
  end

  // Reset holds the arbiter off, so grants and the SRAM request are gated by it.
  assign grant = found & rst_ni;

  // Grant and SRAM port drive; payload is zeroed when nothing is requested.
  always_comb begin
    gnt_o        = '0;
    sram_req_o   = grant;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (grant) begin
      gnt_o        = NumReq'(1) << gidx;
      sram_we_o    = we_i[gidx];
      sram_addr_o  = addr_i[gidx];
      sram_wdata_o = wdata_i[gidx];
      sram_be_o    = be_i[gidx];
    end
  end

  // Priority pointer moves just past the winner; holds when idle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (grant) begin
      ptr_q <= (gidx == IdWidth'(NumReq-1)) ? '0 : gidx + 1'b1;
    end
  end

  // Tag shift register: new read tags enter the top stage, stage 0 is the response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[Latency-1] <= grant & ~we_i[gidx];
      id_pipe[Latency-1]  <= gidx;
      for (int k = 0; k < Latency-1; k++) begin
        vld_pipe[k] <= vld_pipe[k+1];
        id_pipe[k]  <= id_pipe[k+1];
      end
    end
  end

  // Response routing; reset also masks a response that is already at stage 0.
  always_comb begin
    rvalid_o = '0;
    if (rst_ni && vld_pipe[0]) rvalid_o = NumReq'(1) << id_pipe[0];
  end

  assign rdata_o = sram_rdata_i;

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one port of the team's single-cycle generic SRAM macro between NumReq independent requesters.
- Each cycle, round-robin arbitration grants at most one request and drives it onto the SRAM port.
- A Latency-deep tag pipeline routes each read response back to the requester that issued it.
- Sits between core/DMA-side memory clients and one SRAM port; the SRAM accepts a request every cycle and never back-pressures.

Parameters:
- NumReq, 4, number of requesters; must be >= 2.
- AddrWidth, 10, SRAM word-address width.
- DataWidth, 32, data width.
- BeWidth, 4, byte-enable width; equals ceil(DataWidth/8).
- Latency, 1, SRAM read latency in cycles; must be >= 1 and must match the SRAM instance.
- IdWidth, $clog2(NumReq), derived; do not override.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_i  in  NumReq  per-requester request.
- we_i  in  NumReq  per-requester write enable (1 = write).
- addr_i  in  NumReq x AddrWidth  per-requester word address.
- wdata_i  in  NumReq x DataWidth  per-requester write data.
- be_i  in  NumReq x BeWidth  per-requester byte enables.
- gnt_o  out  NumReq  one-hot grant, same cycle as the request.
- rvalid_o  out  NumReq  one-hot read-response valid.
- rdata_o  out  DataWidth  shared read data; meaningful only where rvalid_o is set.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  BeWidth  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid Latency cycles after a read request.

Behaviour:
- Reset is synchronous. While rst_ni = 0 the arbiter is held off:
  - gnt_o, sram_req_o and rvalid_o are forced to 0.
  - The priority pointer is set to 0.
  - All tag-pipeline valid bits are cleared.
- Outputs in the first cycle after reset: gnt_o = 0 until some req_i is high; rvalid_o = 0 for Latency cycles.
- Arbitration (combinational):
  - The granted index g is the first set req_i bit, searching from ptr_q upward and wrapping modulo NumReq.
  - gnt_o = onehot(g) if any req_i is set, else 0.
  - Exactly one grant per cycle, at most.
- A requester holds req_i and its payload stable until it sees gnt_o in the same cycle. A request is consumed in its grant cycle.
- SRAM drive (combinational):
  - sram_req_o = |req_i.
  - sram_we_o, sram_addr_o, sram_wdata_o and sram_be_o are muxed from requester g.
  - When sram_req_o = 0 these outputs are driven to 0.
- Pointer update: on a grant, ptr_q <= (g + 1) mod NumReq, wrapping NumReq-1 -> 0. With no grant, ptr_q holds.
  - Consequence: a continuously requesting client waits at most NumReq-1 cycles.
- Tag pipeline: Latency stages, each holding {valid, id[IdWidth]}.
  - Stage Latency-1 loads {grant && !we_g, g}.
  - Stage k loads stage k+1 every cycle.
  - Stage 0 drives rvalid_o = valid0 ? onehot(id0) : 0.
- Read response:
  - rdata_o = sram_rdata_i, passed through unregistered.
  - A read granted in cycle t gives rvalid_o[g] = 1 in cycle t+Latency with the data at that address.
- Writes produce no rvalid_o.
- A write followed by a read to the same address, granted in later cycles, returns the new data; ordering comes from the single port.
- Back-to-back reads from different requesters each get their response on consecutive cycles, in grant order, with no bubbles.
- Reset mid-operation: in-flight reads are discarded. No rvalid_o is asserted after reset for requests granted before reset.
- Byte enables are passed through unchanged; the arbiter does no merging or splitting.

Test Plan:
- Latency=1, requester 1 reads addr 0x005 (mem = 0xDEADBEEF) in cycle 3 -> gnt_o=4'b0010 in cycle 3; rvalid_o=4'b0010 and rdata_o=0xDEADBEEF in cycle 4; nothing else.
- All four requesters hold req_i=1 (reads) from cycle 0 -> grant order 0,1,2,3,0,1; rvalid_o follows one cycle later in the same order; each rdata_o matches its own address.
- Requester 2 writes 0x11223344 with be=4'b0101 to addr 0x010 (old 0xFFFFFFFF), then reads it -> write gets no rvalid; the read returns 0xFF22FF44.
- Latency=2, requesters 0 and 3 alternate reads to 0x001/0x002 every cycle -> rvalid_o alternates 0001/1000 two cycles after each grant; data is routed correctly; no bubbles.
- Wrap-around: ptr_q=3 and only req_i[0] and req_i[3] set -> grant 3, then 0, then 3; ptr_q sequence 0, 1, 0.
- Latency=2, read granted in cycle 5, rst_ni=0 in cycle 6 -> rvalid_o stays 0 in cycles 6-8; after release the first grant goes to the lowest requesting index.
